// File: rtl/temporal_encoder_if.sv
// Load handshake into the temporal encoder: a spike slot (or null) offered
// under valid/ready.
interface temporal_encoder_if #(
  parameter int VAL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [VAL_W-1:0] in_value;
  logic             in_null;

  modport master (output in_valid, output in_value, output in_null, input in_ready);
  modport slave  (input in_valid, input in_value, input in_null, output in_ready);
endinterface

// File: rtl/temporal_encoder.sv
// Binary-to-temporal encoder: the buffered value promoted on each grst sets the
// slot in which a PULSE_WIDTH-long spike rises within the gamma cycle.
module temporal_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                aclk,
  input  logic                rst,
  input  logic                grst,
  temporal_encoder_if.slave   in_if,
  output logic                spike,
  output logic                act_valid
);

  localparam int            CW  = $clog2(GAMMA_CYCLE_WIDTH) + 1;
  localparam logic [CW-1:0] SAT = CW'(GAMMA_CYCLE_WIDTH);

  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [VAL_W-1:0] pend_value_reg, pend_value_next;
  logic             pend_null_reg, pend_null_next;
  logic [VAL_W-1:0] act_value_reg, act_value_next;
  logic             act_live_reg, act_live_next;
  logic             spike_reg, spike_next;
  logic             load;
  logic [CW:0]      win_lo, win_hi, slot_ext;

  assign load = in_if.in_valid & ~pend_valid_reg;

  always_comb begin
    cnt_next        = cnt_reg;
    pend_valid_next = pend_valid_reg;
    pend_value_next = pend_value_reg;
    pend_null_next  = pend_null_reg;
    act_value_next  = act_value_reg;
    act_live_next   = act_live_reg;

    if (grst) begin
      cnt_next        = '0;
      // Out-of-range values (non-power-of-2 gamma) behave like null.
      act_live_next   = pend_valid_reg & ~pend_null_reg & (CW'(pend_value_reg) < SAT);
      act_value_next  = pend_value_reg;
      pend_valid_next = 1'b0;
    end else if (cnt_reg != SAT) begin
      cnt_next = cnt_reg + CW'(1);
    end

    // A load coinciding with grst lands in pending and waits for the next grst.
    if (load) begin
      pend_valid_next = 1'b1;
      pend_value_next = in_if.in_value;
      pend_null_next  = in_if.in_null;
    end

    // The spike is registered, so the window is evaluated on next-cycle slot/value.
    win_lo     = (CW+1)'(act_value_next);
    win_hi     = win_lo + (CW+1)'(PULSE_WIDTH);
    slot_ext   = {1'b0, cnt_next};
    spike_next = act_live_next && (cnt_next != SAT) &&
                 (slot_ext >= win_lo) && (slot_ext < win_hi);
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      cnt_reg        <= SAT;
      pend_valid_reg <= 1'b0;
      pend_value_reg <= '0;
      pend_null_reg  <= 1'b0;
      act_value_reg  <= '0;
      act_live_reg   <= 1'b0;
      spike_reg      <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      pend_valid_reg <= pend_valid_next;
      pend_value_reg <= pend_value_next;
      pend_null_reg  <= pend_null_next;
      act_value_reg  <= act_value_next;
      act_live_reg   <= act_live_next;
      spike_reg      <= spike_next;
    end
  end

  assign in_if.in_ready = ~pend_valid_reg;
  assign spike          = spike_reg;
  assign act_valid      = act_live_reg;

endmodule
